// File: rtl/dec_frame_assembler.sv
// Decoder-side frame deserialiser: collects a payload word and its check word,
// recomputes the CRC over the payload, and presents all three to the comparator.
module dec_frame_assembler #(
  parameter int unsigned           DATA_DEPTH = 32,
  parameter logic [DATA_DEPTH-1:0] POLY       = DATA_DEPTH'(32'h04C11DB7)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_bit,
  input  logic                  in_sof,
  output logic [DATA_DEPTH-1:0] data_out,
  output logic [DATA_DEPTH-1:0] calc_chk,
  output logic [DATA_DEPTH-1:0] rx_chk,
  output logic                  frame_valid,
  output logic                  frame_abort,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(DATA_DEPTH);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_DEPTH-1:0] crc_q, crc_d;
  logic [DATA_DEPTH-1:0] data_sr_q, data_sr_d;
  logic [DATA_DEPTH-1:0] chk_sr_q, chk_sr_d;
  logic [DATA_DEPTH-1:0] data_out_d, calc_chk_d, rx_chk_d;
  logic                  frame_valid_d, frame_abort_d, busy_d;

  logic [DATA_DEPTH-1:0] crc_step, crc_first, chk_shift;
  logic                  last_bit;

  always_comb begin
    crc_step  = {crc_q[DATA_DEPTH-2:0], 1'b0} ^ ((crc_q[DATA_DEPTH-1] ^ in_bit) ? POLY : '0);
    // CRC of a single bit starting from zero: a fresh frame restarts here
    crc_first = in_bit ? POLY : '0;
    chk_shift = {chk_sr_q[DATA_DEPTH-2:0], in_bit};
    last_bit  = (cnt_q == CW'(DATA_DEPTH - 1));

    state_d       = state_q;
    cnt_d         = cnt_q;
    crc_d         = crc_q;
    data_sr_d     = data_sr_q;
    chk_sr_d      = chk_sr_q;
    data_out_d    = data_out;
    calc_chk_d    = calc_chk;
    rx_chk_d      = rx_chk;
    frame_valid_d = 1'b0;
    frame_abort_d = 1'b0;

    if (in_valid) begin
      if (in_sof) begin
        frame_abort_d = (state_q != IDLE);
        state_d       = PAYLOAD;
        cnt_d         = CW'(1);
        crc_d         = crc_first;
        data_sr_d     = {{(DATA_DEPTH-1){1'b0}}, in_bit};
        chk_sr_d      = '0;
      end else begin
        case (state_q)
          PAYLOAD: begin
            data_sr_d = {data_sr_q[DATA_DEPTH-2:0], in_bit};
            crc_d     = crc_step;
            if (last_bit) begin
              cnt_d   = '0;
              state_d = CHECK;
            end else begin
              cnt_d   = cnt_q + CW'(1);
            end
          end
          CHECK: begin
            chk_sr_d = chk_shift;
            if (last_bit) begin
              cnt_d         = '0;
              state_d       = IDLE;
              data_out_d    = data_sr_q;
              calc_chk_d    = crc_q;
              rx_chk_d      = chk_shift;
              frame_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      crc_q       <= '0;
      data_sr_q   <= '0;
      chk_sr_q    <= '0;
      data_out    <= '0;
      calc_chk    <= '0;
      rx_chk      <= '0;
      frame_valid <= 1'b0;
      frame_abort <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      crc_q       <= crc_d;
      data_sr_q   <= data_sr_d;
      chk_sr_q    <= chk_sr_d;
      data_out    <= data_out_d;
      calc_chk    <= calc_chk_d;
      rx_chk      <= rx_chk_d;
      frame_valid <= frame_valid_d;
      frame_abort <= frame_abort_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_dec_frame_assembler.sv
// Directed bench for dec_frame_assembler at default parameters (32-bit words, CRC-32 poly).
module tb_dec_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_bit, in_sof;
  logic [31:0] data_out, calc_chk, rx_chk;
  logic        frame_valid, frame_abort, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sof_edge = 0;
  int fv_count = 0, fv_edge = 0, fv_prev = 0;
  int ab_count = 0;
  logic [31:0] last_calc = '0, prev_calc = '0;

  dec_frame_assembler #(
    .DATA_DEPTH(32),
    .POLY      (32'h04C11DB7)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_sof     (in_sof),
    .data_out   (data_out),
    .calc_chk   (calc_chk),
    .rx_chk     (rx_chk),
    .frame_valid(frame_valid),
    .frame_abort(frame_abort),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // fv_edge is the rising edge at which a downstream register captures the pulse
  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count++;
      fv_prev   = fv_edge;
      fv_edge   = cyc + 1;
      prev_calc = last_calc;
      last_calc = calc_chk;
    end
    if (frame_abort) ab_count++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] pay, input logic [31:0] ck,
                           input int first, input int last, input bit stall);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = (i == 0);
      in_bit   = (i < 32) ? pay[31-i] : ck[63-i];
      if (i == 0) sof_edge = cyc + 1;
      if (stall && i != last) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b1;
        in_bit   = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_bit   = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", 64'(data_out), 64'h0);
    chk("rst_calc", 64'(calc_chk), 64'h0);
    chk("rst_rx", 64'(rx_chk), 64'h0);
    chk("rst_fv", 64'(frame_valid), 64'h0);
    chk("rst_abort", 64'(frame_abort), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    rst = 1'b0;
    idle(2);

    // all-zero frame
    send_bits(32'h0, 32'h0, 0, 63, 1'b0);
    idle(3);
    chk("f0_count", 64'(fv_count), 64'd1);
    chk("f0_latency", 64'(fv_edge - sof_edge), 64'd64);
    chk("f0_data", 64'(data_out), 64'h0);
    chk("f0_calc", 64'(calc_chk), 64'h0);
    chk("f0_rx", 64'(rx_chk), 64'h0);
    chk("f0_eq", 64'(calc_chk == rx_chk), 64'd1);

    send_bits(32'h00000001, 32'h04C11DB7, 0, 63, 1'b0);
    idle(3);
    chk("f1_count", 64'(fv_count), 64'd2);
    chk("f1_data", 64'(data_out), 64'h00000001);
    chk("f1_calc", 64'(calc_chk), 64'h04C11DB7);
    chk("f1_eq", 64'(calc_chk == rx_chk), 64'd1);

    send_bits(32'h00000001, 32'h04C11DB6, 0, 63, 1'b0);
    idle(3);
    chk("f2_rx", 64'(rx_chk), 64'h04C11DB6);
    chk("f2_eq", 64'(calc_chk == rx_chk), 64'd0);
    idle(20);
    chk("f2_hold_rx", 64'(rx_chk), 64'h04C11DB6);
    chk("f2_hold_count", 64'(fv_count), 64'd3);

    // 64 accepted bits separated by 63 stall cycles
    send_bits(32'h00000001, 32'h04C11DB7, 0, 63, 1'b1);
    idle(3);
    chk("st_count", 64'(fv_count), 64'd4);
    chk("st_latency", 64'(fv_edge - sof_edge), 64'd127);
    chk("st_data", 64'(data_out), 64'h00000001);
    chk("st_calc", 64'(calc_chk), 64'h04C11DB7);
    chk("st_rx", 64'(rx_chk), 64'h04C11DB7);

    // abort: new sof 40 bits into a frame
    send_bits(32'hDEADBEEF, 32'hCAFEF00D, 0, 39, 1'b0);
    chk("ab_busy", 64'(busy), 64'd1);
    send_bits(32'h00000002, 32'h09823B6E, 0, 9, 1'b0);
    chk("ab_pulse", 64'(ab_count), 64'd1);
    chk("ab_no_fv", 64'(fv_count), 64'd4);
    chk("ab_hold_data", 64'(data_out), 64'h00000001);
    chk("ab_hold_rx", 64'(rx_chk), 64'h04C11DB7);
    send_bits(32'h00000002, 32'h09823B6E, 10, 63, 1'b0);
    idle(3);
    chk("ab_new_count", 64'(fv_count), 64'd5);
    chk("ab_new_data", 64'(data_out), 64'h00000002);
    chk("ab_new_calc", 64'(calc_chk), 64'h09823B6E);
    chk("ab_new_eq", 64'(calc_chk == rx_chk), 64'd1);
    chk("ab_single", 64'(ab_count), 64'd1);

    // reset 10 bits into a frame
    send_bits(32'h00000003, 32'h0D4326D9, 0, 9, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_data", 64'(data_out), 64'h0);
    chk("mr_calc", 64'(calc_chk), 64'h0);
    chk("mr_rx", 64'(rx_chk), 64'h0);
    chk("mr_busy", 64'(busy), 64'd0);
    send_bits(32'h00000003, 32'h0D4326D9, 10, 30, 1'b0);
    idle(3);
    chk("mr_trail_busy", 64'(busy), 64'd0);
    chk("mr_trail_fv", 64'(fv_count), 64'd5);
    chk("mr_no_abort", 64'(ab_count), 64'd1);

    send_bits(32'h00000003, 32'h0D4326D9, 0, 63, 1'b0);
    send_bits(32'h00000002, 32'h09823B6E, 0, 63, 1'b0);
    idle(3);
    chk("bb_count", 64'(fv_count), 64'd7);
    chk("bb_spacing", 64'(fv_edge - fv_prev), 64'd64);
    chk("bb_first_calc", 64'(prev_calc), 64'h0D4326D9);
    chk("bb_data", 64'(data_out), 64'h00000002);
    chk("bb_calc", 64'(calc_chk), 64'h09823B6E);
    chk("bb_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
